// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset sequencer: FETCH/DECODE/EXEC/MEM/WB with
// memready handshake, multi-cycle shifts and sticky traps.
module multicycle_control #(
  parameter int unsigned SHIFT_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] fn,
  input  logic       memready,
  output logic       readmem,
  output logic       writemem,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       writereg,
  output logic [2:0] selwsource,
  output logic [1:0] selregdest,
  output logic       selimregb,
  output logic       selalushift,
  output logic       unsig,
  output logic [2:0] aluop,
  output logic [1:0] shiftop,
  output logic [1:0] selbrjumpz,
  output logic [2:0] compop,
  output logic [2:0] state,
  output logic       illegal,
  output logic       memfault
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  typedef enum logic [4:0] {
    C_NONE, C_ADD, C_ADDU, C_SUB, C_SUBU,
    C_AND, C_OR, C_XOR, C_NOR,
    C_SLLV, C_SRLV, C_SRAV, C_JR, C_J,
    C_BEQ, C_BNE, C_BLEZ, C_BGTZ,
    C_ADDI, C_ADDIU, C_ANDI, C_ORI, C_XORI,
    C_LW, C_SW
  } cls_e;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);
  localparam logic [3:0] SH_LOAD   = 4'(SHIFT_CYCLES - 1);

  state_e     state_q, state_d;
  cls_e       cls_q, cls_d, dec_cls;
  logic [7:0] wcnt_q, wcnt_d, wcnt_inc;
  logic [3:0] shcnt_q, shcnt_d;
  logic       ill_q, ill_d;
  logic       mf_q, mf_d;
  logic       is_rtype;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cls_q   <= C_NONE;
      wcnt_q  <= '0;
      shcnt_q <= '0;
      ill_q   <= 1'b0;
      mf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      wcnt_q  <= wcnt_d;
      shcnt_q <= shcnt_d;
      ill_q   <= ill_d;
      mf_q    <= mf_d;
    end
  end

  always_comb begin
    dec_cls = C_NONE;
    unique case (op)
      6'b000000: begin
        unique case (fn)
          6'b000100: dec_cls = C_SLLV;
          6'b000110: dec_cls = C_SRLV;
          6'b000111: dec_cls = C_SRAV;
          6'b001000: dec_cls = C_JR;
          6'b100000: dec_cls = C_ADD;
          6'b100001: dec_cls = C_ADDU;
          6'b100010: dec_cls = C_SUB;
          6'b100011: dec_cls = C_SUBU;
          6'b100100: dec_cls = C_AND;
          6'b100101: dec_cls = C_OR;
          6'b100110: dec_cls = C_XOR;
          6'b100111: dec_cls = C_NOR;
          default:   dec_cls = C_NONE;
        endcase
      end
      6'b000010: dec_cls = C_J;
      6'b000100: dec_cls = C_BEQ;
      6'b000101: dec_cls = C_BNE;
      6'b000110: dec_cls = C_BLEZ;
      6'b000111: dec_cls = C_BGTZ;
      6'b001000: dec_cls = C_ADDI;
      6'b001001: dec_cls = C_ADDIU;
      6'b001100: dec_cls = C_ANDI;
      6'b001101: dec_cls = C_ORI;
      6'b001110: dec_cls = C_XORI;
      6'b100011: dec_cls = C_LW;
      6'b101011: dec_cls = C_SW;
      default:   dec_cls = C_NONE;
    endcase
  end

  assign is_rtype = cls_q inside {
    C_ADD, C_ADDU, C_SUB, C_SUBU, C_AND, C_OR,
    C_XOR, C_NOR, C_SLLV, C_SRLV, C_SRAV
  };

  assign wcnt_inc = (wcnt_q == 8'hFF) ? wcnt_q : wcnt_q + 8'd1;

  always_comb begin
    readmem     = 1'b0;
    writemem    = 1'b0;
    irwrite     = 1'b0;
    pcwrite     = 1'b0;
    writereg    = 1'b0;
    selwsource  = 3'b000;
    selregdest  = 2'b00;
    selimregb   = 1'b0;
    selalushift = 1'b0;
    unsig       = 1'b0;
    aluop       = 3'b000;
    shiftop     = 2'b00;
    selbrjumpz  = 2'b00;
    compop      = 3'b000;
    state_d     = state_q;
    cls_d       = cls_q;
    shcnt_d     = shcnt_q;
    ill_d       = ill_q;
    mf_d        = mf_q;
    // Any cycle not spent waiting clears the wait counter.
    wcnt_d      = '0;
    if (!reset) begin
      unique case (state_q)
        S_FETCH: begin
          readmem = 1'b1;
          if (memready) begin
            irwrite = 1'b1;
            pcwrite = 1'b1;
            state_d = S_DECODE;
          end else if (wcnt_q == WAIT_LAST) begin
            mf_d    = 1'b1;
            state_d = S_TRAP;
          end else begin
            wcnt_d = wcnt_inc;
          end
        end
        S_DECODE: begin
          cls_d   = dec_cls;
          shcnt_d = SH_LOAD;
          if (dec_cls == C_NONE) begin
            ill_d   = 1'b1;
            state_d = S_TRAP;
          end else begin
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          state_d = S_WB;
          unique case (cls_q)
            C_ADD:   aluop = 3'b010;
            C_ADDU:  begin aluop = 3'b010; unsig = 1'b1; end
            C_SUB:   aluop = 3'b110;
            C_SUBU:  begin aluop = 3'b110; unsig = 1'b1; end
            C_AND:   aluop = 3'b000;
            C_OR:    aluop = 3'b001;
            C_XOR:   aluop = 3'b011;
            C_NOR:   aluop = 3'b100;
            C_ADDI:  begin aluop = 3'b010; selimregb = 1'b1; end
            C_ADDIU: begin
              aluop = 3'b010; selimregb = 1'b1; unsig = 1'b1;
            end
            C_ANDI:  begin
              aluop = 3'b000; selimregb = 1'b1; unsig = 1'b1;
            end
            C_ORI:   begin
              aluop = 3'b001; selimregb = 1'b1; unsig = 1'b1;
            end
            C_XORI:  begin
              aluop = 3'b011; selimregb = 1'b1; unsig = 1'b1;
            end
            C_SLLV, C_SRLV, C_SRAV: begin
              selalushift = 1'b1;
              shiftop = (cls_q == C_SLLV) ? 2'b10 :
                        (cls_q == C_SRAV) ? 2'b01 : 2'b00;
              if (shcnt_q != 4'd0) begin
                shcnt_d = shcnt_q - 4'd1;
                state_d = S_EXEC;
              end
            end
            C_LW, C_SW: begin
              aluop     = 3'b010;
              selimregb = 1'b1;
              state_d   = S_MEM;
            end
            C_J: begin
              selbrjumpz = 2'b10; pcwrite = 1'b1; state_d = S_FETCH;
            end
            C_JR: begin
              selbrjumpz = 2'b01; pcwrite = 1'b1; state_d = S_FETCH;
            end
            C_BEQ, C_BNE, C_BLEZ, C_BGTZ: begin
              selbrjumpz = 2'b10;
              pcwrite    = 1'b1;
              compop     = (cls_q == C_BEQ)  ? 3'b000 :
                           (cls_q == C_BNE)  ? 3'b001 :
                           (cls_q == C_BLEZ) ? 3'b010 : 3'b011;
              state_d    = S_FETCH;
            end
            default: state_d = S_TRAP;
          endcase
        end
        S_MEM: begin
          readmem  = (cls_q == C_LW);
          writemem = (cls_q == C_SW);
          if (memready) begin
            state_d = (cls_q == C_LW) ? S_WB : S_FETCH;
          end else if (wcnt_q == WAIT_LAST) begin
            mf_d    = 1'b1;
            state_d = S_TRAP;
          end else begin
            wcnt_d = wcnt_inc;
          end
        end
        S_WB: begin
          writereg   = 1'b1;
          selwsource = (cls_q == C_LW) ? 3'b001 : 3'b000;
          selregdest = is_rtype ? 2'b01 : 2'b00;
          state_d    = S_FETCH;
        end
        S_TRAP: state_d = S_TRAP;
        default: state_d = S_TRAP;
      endcase
    end
  end

  assign state    = state_q;
  assign illegal  = ill_q;
  assign memfault = mf_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-cycle expected traces built from
// an instruction table and wait counts, checked by scenario tasks.
module tb_multicycle_control;

  localparam int SHC = 3;
  localparam int MTO = 4;

  localparam int K_ALUR = 0;
  localparam int K_ALUI = 1;
  localparam int K_SH   = 2;
  localparam int K_LW   = 3;
  localparam int K_SW   = 4;
  localparam int K_J    = 5;
  localparam int K_JR   = 6;
  localparam int K_BR   = 7;
  localparam int K_ILL  = 8;

  typedef struct packed {
    logic [2:0] st;
    logic       rd;
    logic       wr;
    logic       irw;
    logic       pcw;
    logic       wreg;
    logic [2:0] wsrc;
    logic [1:0] rdst;
    logic       imb;
    logic       alsh;
    logic       uns;
    logic [2:0] aop;
    logic [1:0] sop;
    logic [1:0] bj;
    logic [2:0] cop;
    logic       ill;
    logic       mf;
  } exp_t;

  typedef struct {
    logic       mr;
    logic [5:0] op;
    logic [5:0] fn;
    exp_t       e;
  } cyc_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int         kind;
    logic [2:0] aop;
    logic       uns;
    logic [1:0] sop;
    logic [2:0] cop;
  } ins_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = '0;
  logic [5:0] fn = '0;
  logic       memready = 1'b0;
  logic       readmem, writemem, irwrite, pcwrite, writereg;
  logic [2:0] selwsource;
  logic [1:0] selregdest;
  logic       selimregb, selalushift, unsig;
  logic [2:0] aluop;
  logic [1:0] shiftop, selbrjumpz;
  logic [2:0] compop, state;
  logic       illegal, memfault;

  int   ncmp = 0;
  int   nfail = 0;
  ins_t tbl[24];
  cyc_t q[$];

  multicycle_control #(
    .SHIFT_CYCLES(SHC),
    .MEM_TIMEOUT (MTO)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .op         (op),
    .fn         (fn),
    .memready   (memready),
    .readmem    (readmem),
    .writemem   (writemem),
    .irwrite    (irwrite),
    .pcwrite    (pcwrite),
    .writereg   (writereg),
    .selwsource (selwsource),
    .selregdest (selregdest),
    .selimregb  (selimregb),
    .selalushift(selalushift),
    .unsig      (unsig),
    .aluop      (aluop),
    .shiftop    (shiftop),
    .selbrjumpz (selbrjumpz),
    .compop     (compop),
    .state      (state),
    .illegal    (illegal),
    .memfault   (memfault)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t obs();
    exp_t o;
    o.st = state; o.rd = readmem; o.wr = writemem;
    o.irw = irwrite; o.pcw = pcwrite; o.wreg = writereg;
    o.wsrc = selwsource; o.rdst = selregdest;
    o.imb = selimregb; o.alsh = selalushift; o.uns = unsig;
    o.aop = aluop; o.sop = shiftop; o.bj = selbrjumpz;
    o.cop = compop; o.ill = illegal; o.mf = memfault;
    return o;
  endfunction

  function automatic logic [5:0] rnd6();
    return 6'($urandom);
  endfunction

  task automatic init_tbl();
    tbl[0]  = '{6'h00, 6'h04, K_SH,   3'b000, 1'b0, 2'b10, 3'b000};
    tbl[1]  = '{6'h00, 6'h06, K_SH,   3'b000, 1'b0, 2'b00, 3'b000};
    tbl[2]  = '{6'h00, 6'h07, K_SH,   3'b000, 1'b0, 2'b01, 3'b000};
    tbl[3]  = '{6'h00, 6'h08, K_JR,   3'b000, 1'b0, 2'b00, 3'b000};
    tbl[4]  = '{6'h00, 6'h20, K_ALUR, 3'b010, 1'b0, 2'b00, 3'b000};
    tbl[5]  = '{6'h00, 6'h21, K_ALUR, 3'b010, 1'b1, 2'b00, 3'b000};
    tbl[6]  = '{6'h00, 6'h22, K_ALUR, 3'b110, 1'b0, 2'b00, 3'b000};
    tbl[7]  = '{6'h00, 6'h23, K_ALUR, 3'b110, 1'b1, 2'b00, 3'b000};
    tbl[8]  = '{6'h00, 6'h24, K_ALUR, 3'b000, 1'b0, 2'b00, 3'b000};
    tbl[9]  = '{6'h00, 6'h25, K_ALUR, 3'b001, 1'b0, 2'b00, 3'b000};
    tbl[10] = '{6'h00, 6'h26, K_ALUR, 3'b011, 1'b0, 2'b00, 3'b000};
    tbl[11] = '{6'h00, 6'h27, K_ALUR, 3'b100, 1'b0, 2'b00, 3'b000};
    tbl[12] = '{6'h02, 6'h00, K_J,    3'b000, 1'b0, 2'b00, 3'b000};
    tbl[13] = '{6'h04, 6'h00, K_BR,   3'b000, 1'b0, 2'b00, 3'b000};
    tbl[14] = '{6'h05, 6'h00, K_BR,   3'b000, 1'b0, 2'b00, 3'b001};
    tbl[15] = '{6'h06, 6'h00, K_BR,   3'b000, 1'b0, 2'b00, 3'b010};
    tbl[16] = '{6'h07, 6'h00, K_BR,   3'b000, 1'b0, 2'b00, 3'b011};
    tbl[17] = '{6'h08, 6'h00, K_ALUI, 3'b010, 1'b0, 2'b00, 3'b000};
    tbl[18] = '{6'h09, 6'h00, K_ALUI, 3'b010, 1'b1, 2'b00, 3'b000};
    tbl[19] = '{6'h0C, 6'h00, K_ALUI, 3'b000, 1'b1, 2'b00, 3'b000};
    tbl[20] = '{6'h0D, 6'h00, K_ALUI, 3'b001, 1'b1, 2'b00, 3'b000};
    tbl[21] = '{6'h0E, 6'h00, K_ALUI, 3'b011, 1'b1, 2'b00, 3'b000};
    tbl[22] = '{6'h23, 6'h00, K_LW,   3'b000, 1'b0, 2'b00, 3'b000};
    tbl[23] = '{6'h2B, 6'h00, K_SW,   3'b000, 1'b0, 2'b00, 3'b000};
  endtask

  function automatic int lookup(logic [5:0] o, logic [5:0] f);
    for (int i = 0; i < 24; i++)
      if (tbl[i].op == o && (o != 6'h00 || tbl[i].fn == f))
        return i;
    return -1;
  endfunction

  task automatic push(input logic mr, input logic [5:0] o,
                      input logic [5:0] f, input exp_t e);
    cyc_t c;
    c.mr = mr; c.op = o; c.fn = f; c.e = e;
    q.push_back(c);
  endtask

  function automatic logic imr(bit tie);
    return tie ? 1'b1 : 1'($urandom);
  endfunction

  function automatic logic [5:0] pick(bit fixed, logic [5:0] v);
    return fixed ? v : rnd6();
  endfunction

  task automatic trap(input int n, input logic il, input logic mf,
                      input bit tie, input bit fixed,
                      input logic [5:0] po, input logic [5:0] pf);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e = '0; e.st = 3'd5; e.ill = il; e.mf = mf;
      push(imr(tie), pick(fixed, po), pick(fixed, pf), e);
    end
  endtask

  // Reference trace for one instruction: wf/wm are the memready-low
  // cycles before the FETCH and MEM completions.
  task automatic model_instr(input logic [5:0] o, input logic [5:0] f,
                             input int wf, input int wm,
                             input bit fixed, input logic [5:0] po,
                             input logic [5:0] pf, input bit tie);
    exp_t e;
    int   idx, kind, n;
    idx  = lookup(o, f);
    kind = (idx < 0) ? K_ILL : tbl[idx].kind;
    for (int i = 0; i < wf && i < MTO; i++) begin
      e = '0; e.rd = 1'b1;
      push(1'b0, pick(fixed, po), pick(fixed, pf), e);
    end
    if (wf >= MTO) begin
      trap(8, 1'b0, 1'b1, tie, fixed, po, pf);
      return;
    end
    e = '0; e.rd = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
    push(1'b1, pick(fixed, po), pick(fixed, pf), e);
    e = '0; e.st = 3'd1;
    push(imr(tie), o, f, e);
    if (kind == K_ILL) begin
      trap(20, 1'b1, 1'b0, tie, fixed, po, pf);
      return;
    end
    e = '0; e.st = 3'd2;
    n = (kind == K_SH) ? SHC : 1;
    case (kind)
      K_ALUR: begin e.aop = tbl[idx].aop; e.uns = tbl[idx].uns; end
      K_ALUI: begin
        e.aop = tbl[idx].aop; e.uns = tbl[idx].uns; e.imb = 1'b1;
      end
      K_SH:   begin e.alsh = 1'b1; e.sop = tbl[idx].sop; end
      K_LW, K_SW: begin e.aop = 3'b010; e.imb = 1'b1; end
      K_J:    begin e.bj = 2'b10; e.pcw = 1'b1; end
      K_JR:   begin e.bj = 2'b01; e.pcw = 1'b1; end
      default: begin
        e.bj = 2'b10; e.pcw = 1'b1; e.cop = tbl[idx].cop;
      end
    endcase
    for (int i = 0; i < n; i++)
      push(imr(tie), pick(fixed, po), pick(fixed, pf), e);
    if (kind == K_LW || kind == K_SW) begin
      e = '0; e.st = 3'd3;
      e.rd = (kind == K_LW); e.wr = (kind == K_SW);
      for (int i = 0; i < wm && i < MTO; i++)
        push(1'b0, pick(fixed, po), pick(fixed, pf), e);
      if (wm >= MTO) begin
        trap(8, 1'b0, 1'b1, tie, fixed, po, pf);
        return;
      end
      push(1'b1, pick(fixed, po), pick(fixed, pf), e);
    end
    if (kind inside {K_ALUR, K_ALUI, K_SH, K_LW}) begin
      e = '0; e.st = 3'd4; e.wreg = 1'b1;
      e.wsrc = (kind == K_LW) ? 3'b001 : 3'b000;
      e.rdst = (kind == K_ALUR || kind == K_SH) ? 2'b01 : 2'b00;
      push(imr(tie), pick(fixed, po), pick(fixed, pf), e);
    end
  endtask

  // One clock cycle: drive at the falling edge, sample before rising.
  task automatic step(input logic mr, input logic [5:0] o,
                      input logic [5:0] f, output exp_t ob);
    @(negedge clock);
    reset = 1'b0; memready = mr; op = o; fn = f;
    #2;
    ob = obs();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; memready = 1'b0;
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    exp_t ob, want;
    @(negedge clock);
    reset = 1'b1; memready = 1'b1; op = 6'h20; fn = 6'h20;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); #2;
      ob = obs(); ncmp++;
      if (ob !== '0) begin
        nfail++;
        $display("FAIL reset_hold got=%h want=0", ob);
      end
    end
    step(1'b0, 6'h00, 6'h20, ob);
    want = '0; want.rd = 1'b1; ncmp++;
    if (ob !== want) begin
      nfail++;
      $display("FAIL reset_first got=%h want=%h", ob, want);
    end
    step(1'b1, 6'h00, 6'h20, ob);
    want.irw = 1'b1; want.pcw = 1'b1; ncmp++;
    if (ob !== want) begin
      nfail++;
      $display("FAIL reset_fetch got=%h want=%h", ob, want);
    end
  endtask

  task automatic test_add();
    cyc_t c; exp_t ob; int k, wr_n;
    do_reset();
    model_instr(6'h00, 6'h20, 0, 0, 1'b1, 6'h00, 6'h20, 1'b1);
    k = 0; wr_n = 0;
    while (q.size() > 0) begin
      c = q.pop_front();
      step(c.mr, c.op, c.fn, ob);
      wr_n += int'(ob.wreg); ncmp++;
      if (ob !== c.e) begin
        nfail++;
        $display("FAIL add cyc%0d got=%h want=%h", k, ob, c.e);
      end
      k++;
    end
    ncmp++;
    if (wr_n != 1) begin
      nfail++;
      $display("FAIL add_writereg got=%0d want=1", wr_n);
    end
  endtask

  task automatic test_srav();
    cyc_t c; exp_t ob; int k;
    do_reset();
    model_instr(6'h00, 6'h07, 0, 0, 1'b0, 6'h0, 6'h0, 1'b0);
    k = 0;
    while (q.size() > 0) begin
      c = q.pop_front();
      step(c.mr, c.op, c.fn, ob);
      ncmp++;
      if (ob !== c.e) begin
        nfail++;
        $display("FAIL srav cyc%0d got=%h want=%h", k, ob, c.e);
      end
      k++;
    end
  endtask

  task automatic test_lw_wait();
    cyc_t c; exp_t ob; int k, rd_n;
    do_reset();
    model_instr(6'h23, 6'h00, 0, 2, 1'b0, 6'h0, 6'h0, 1'b0);
    k = 0; rd_n = 0;
    while (q.size() > 0) begin
      c = q.pop_front();
      step(c.mr, c.op, c.fn, ob);
      if (ob.st == 3'd3) rd_n += int'(ob.rd);
      ncmp++;
      if (ob !== c.e) begin
        nfail++;
        $display("FAIL lw_wait cyc%0d got=%h want=%h", k, ob, c.e);
      end
      k++;
    end
    ncmp++;
    if (rd_n != 3) begin
      nfail++;
      $display("FAIL lw_mem_readmem got=%0d want=3", rd_n);
    end
  endtask

  task automatic test_illegal();
    cyc_t c; exp_t ob; int k;
    logic [5:0] bad [2];
    bad[0] = 6'h3F; bad[1] = 6'h00;
    for (int t = 0; t < 2; t++) begin
      do_reset();
      model_instr(bad[t], 6'h00, 0, 0, 1'b0, 6'h0, 6'h0, 1'b0);
      k = 0;
      while (q.size() > 0) begin
        c = q.pop_front();
        step(c.mr, c.op, c.fn, ob);
        ncmp++;
        if (ob !== c.e) begin
          nfail++;
          $display("FAIL illegal%0d cyc%0d got=%h want=%h",
                   t, k, ob, c.e);
        end
        k++;
      end
      @(negedge clock);
      reset = 1'b1;
      #2;
      ob = obs(); ncmp++;
      if (ob.st !== 3'd0 || ob.ill !== 1'b0) begin
        nfail++;
        $display("FAIL illegal_clear st=%0d ill=%0b want st=0 ill=0",
                 ob.st, ob.ill);
      end
    end
  endtask

  task automatic test_timeout();
    cyc_t c; exp_t ob; int k;
    int wf [3];
    wf[0] = MTO; wf[1] = MTO - 1; wf[2] = 0;
    for (int t = 0; t < 3; t++) begin
      do_reset();
      if (t < 2)
        model_instr(6'h00, 6'h21, wf[t], 0, 1'b0, 6'h0, 6'h0, 1'b0);
      else
        model_instr(6'h2B, 6'h00, 0, MTO, 1'b0, 6'h0, 6'h0, 1'b0);
      k = 0;
      while (q.size() > 0) begin
        c = q.pop_front();
        step(c.mr, c.op, c.fn, ob);
        ncmp++;
        if (ob !== c.e) begin
          nfail++;
          $display("FAIL timeout%0d cyc%0d got=%h want=%h",
                   t, k, ob, c.e);
        end
        k++;
      end
    end
  endtask

  task automatic test_bne_scramble();
    cyc_t c; exp_t ob; int k, wm_n;
    do_reset();
    model_instr(6'h05, 6'h00, 1, 0, 1'b1, 6'h2B, 6'h2B, 1'b0);
    k = 0; wm_n = 0;
    while (q.size() > 0) begin
      c = q.pop_front();
      step(c.mr, c.op, c.fn, ob);
      wm_n += int'(ob.wr); ncmp++;
      if (ob !== c.e) begin
        nfail++;
        $display("FAIL bne cyc%0d got=%h want=%h", k, ob, c.e);
      end
      k++;
    end
    step(1'b0, 6'h2B, 6'h2B, ob);
    ncmp++;
    if (ob.st !== 3'd0 || wm_n != 0) begin
      nfail++;
      $display("FAIL bne_after st=%0d wm=%0d want st=0 wm=0",
               ob.st, wm_n);
    end
  endtask

  task automatic test_mid_reset();
    cyc_t c; exp_t ob; int k;
    do_reset();
    model_instr(6'h2B, 6'h00, 0, 3, 1'b0, 6'h0, 6'h0, 1'b0);
    for (k = 0; k < 4; k++) begin
      c = q.pop_front();
      step(c.mr, c.op, c.fn, ob);
      ncmp++;
      if (ob !== c.e) begin
        nfail++;
        $display("FAIL midrst cyc%0d got=%h want=%h", k, ob, c.e);
      end
    end
    q.delete();
    #1 reset = 1'b1;
    #1 ob = obs();
    ncmp++;
    if (ob !== '0) begin
      nfail++;
      $display("FAIL midrst_async got=%h want=0", ob);
    end
    do_reset();
    model_instr(6'h0D, 6'h00, 2, 0, 1'b0, 6'h0, 6'h0, 1'b0);
    k = 0;
    while (q.size() > 0) begin
      c = q.pop_front();
      step(c.mr, c.op, c.fn, ob);
      ncmp++;
      if (ob !== c.e) begin
        nfail++;
        $display("FAIL midrst_after cyc%0d got=%h want=%h",
                 k, ob, c.e);
      end
      k++;
    end
  endtask

  task automatic test_back_to_back();
    cyc_t c; exp_t ob; int k, idx;
    do_reset();
    for (int i = 0; i < 24 + 40; i++) begin
      idx = (i < 24) ? i : int'($urandom_range(0, 23));
      model_instr(tbl[idx].op, tbl[idx].fn,
                  int'($urandom_range(0, MTO - 1)),
                  int'($urandom_range(0, MTO - 1)),
                  1'b0, 6'h0, 6'h0, 1'b0);
    end
    k = 0;
    while (q.size() > 0) begin
      c = q.pop_front();
      step(c.mr, c.op, c.fn, ob);
      ncmp++;
      if (ob !== c.e) begin
        nfail++;
        $display("FAIL b2b cyc%0d got=%h want=%h", k, ob, c.e);
      end
      k++;
    end
  endtask

  initial begin
    init_tbl();
    test_reset();
    test_add();
    test_srav();
    test_lw_wait();
    test_illegal();
    test_timeout();
    test_bne_scramble();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
